// File: rtl/temp_filter_pkg.sv
// rtl/temp_filter_pkg.sv - shared types, constants and averaging helper for temp_filter
// Contents: state_t (FILL/RUN/STALE), TEMP_W, WIN_DEPTH, NEUTRAL_TEMP, avg4().
package temp_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALE = 2'd2
    } state_t;

    localparam int TEMP_W    = 5;
    localparam int WIN_DEPTH = 4;

    localparam logic [TEMP_W-1:0] NEUTRAL_TEMP = 5'd20;

    // Four 5-bit values sum to at most 124, so a 7-bit sum never overflows
    // and dropping the two LSBs always leaves a 5-bit truncated mean.
    function automatic logic [TEMP_W-1:0] avg4(
        input logic [TEMP_W-1:0] a,
        input logic [TEMP_W-1:0] b,
        input logic [TEMP_W-1:0] c,
        input logic [TEMP_W-1:0] d
    );
        logic [6:0] sum;
        sum = 7'(a) + 7'(b) + 7'(c) + 7'(d);
        return sum[6:2];
    endfunction

endpackage

// File: rtl/temp_filter_stale_timer.sv
// rtl/temp_filter_stale_timer.sv - saturating idle counter that flags a stale input
// Ports: clk, rst (sync, active-high), kick (clears the count),
//        expired (high while the count sits at TIMEOUT_CYCLES).
module stale_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic expired
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("stale_timer: TIMEOUT_CYCLES must be within 2..255");
    end

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (kick) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/temp_filter.sv
// rtl/temp_filter.sv - 4-sample moving-average temperature filter with stale detection
// Ports: clk, rst (sync, active-high), sample_valid/sample (raw 5-bit reading),
//        temperature/temp_valid (filtered output), stale (input timed out),
//        spike_rej (one-cycle pulse per discarded sample).
// Build option: define TEMP_FILTER_SPIKE_REJECT_EN to compile in spike rejection
//        in RUN; otherwise every sample is accepted and spike_rej is tied low.
module temp_filter
    import temp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SPIKE_DELTA    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              stale,
    output logic              spike_rej
);

    if (SPIKE_DELTA < 0 || SPIKE_DELTA > 31) begin : g_bad_spike_delta
        $error("temp_filter: SPIKE_DELTA must be within 0..31");
    end

    state_t            state;
    logic [TEMP_W-1:0] win [WIN_DEPTH];   // win[0] newest, win[3] oldest
    logic [1:0]        fill_cnt;
    logic              accept;
    logic              expired;
    logic [TEMP_W-1:0] avg_next;

    // Any sample_valid, even a rejected one, proves the sensor is alive.
    stale_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stale_timer (
        .clk     (clk),
        .rst     (rst),
        .kick    (sample_valid),
        .expired (expired)
    );

`ifdef TEMP_FILTER_SPIKE_REJECT_EN
    localparam logic [TEMP_W-1:0] DELTA = TEMP_W'(SPIKE_DELTA);

    logic [1:0]        rej_cnt;
    logic [TEMP_W-1:0] diff;
    logic              out_band;

    always_comb begin
        diff     = (sample >= temperature) ? (sample - temperature)
                                           : (temperature - sample);
        out_band = (state == RUN) && (diff > DELTA);
        // Two discards in a row already happened: treat the third as a real step.
        accept   = sample_valid && (!out_band || (rej_cnt == 2'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_cnt   <= '0;
            spike_rej <= 1'b0;
        end else begin
            spike_rej <= sample_valid && !accept;
            if (accept) begin
                rej_cnt <= '0;
            end else if (sample_valid) begin
                rej_cnt <= rej_cnt + 2'd1;
            end
        end
    end
`else
    assign accept    = sample_valid;
    assign spike_rej = 1'b0;
`endif

    // Average of the window as it will look once the current sample is shifted in.
    assign avg_next = avg4(sample, win[0], win[1], win[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            temperature <= NEUTRAL_TEMP;
            temp_valid  <= 1'b0;
            stale       <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        win[0] <= sample;
                        for (int i = 1; i < WIN_DEPTH; i++) begin
                            win[i] <= win[i-1];
                        end
                        fill_cnt <= fill_cnt + 2'd1;   // wraps to 0 on the 4th sample
                        if (fill_cnt == 2'd3) begin
                            temperature <= avg_next;
                            temp_valid  <= 1'b1;
                            state       <= RUN;
                        end
                    end else if (expired && !sample_valid) begin
                        state       <= STALE;
                        stale       <= 1'b1;
                        temp_valid  <= 1'b0;
                        temperature <= NEUTRAL_TEMP;
                    end
                end
                RUN: begin
                    if (accept) begin
                        win[0] <= sample;
                        for (int i = 1; i < WIN_DEPTH; i++) begin
                            win[i] <= win[i-1];
                        end
                        temperature <= avg_next;
                    end else if (expired && !sample_valid) begin
                        // A rejected sample on the timeout cycle still counts as activity.
                        state       <= STALE;
                        stale       <= 1'b1;
                        temp_valid  <= 1'b0;
                        temperature <= NEUTRAL_TEMP;
                    end
                end
                STALE: begin
                    if (sample_valid) begin
                        win[0] <= sample;
                        for (int i = 1; i < WIN_DEPTH; i++) begin
                            win[i] <= '0;
                        end
                        fill_cnt <= 2'd1;
                        stale    <= 1'b0;
                        state    <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_filter.sv
// tb/tb_temp_filter.sv - directed scoreboard bench for temp_filter
module tb_temp_filter;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [4:0] sample;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       stale;
    logic       spike_rej;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] temp;
        logic       valid;
        logic       stl;
        logic       spk;
    } exp_t;

    exp_t sb[$];

    temp_filter #(
        .TIMEOUT_CYCLES (8),
        .SPIKE_DELTA    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .stale        (stale),
        .spike_rej    (spike_rej)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] et, input logic ev,
                           input logic es, input logic esr);
        chk({tag, ".temperature"}, 8'(temperature), 8'(et));
        chk({tag, ".temp_valid"},  8'(temp_valid),  8'(ev));
        chk({tag, ".stale"},       8'(stale),       8'(es));
        chk({tag, ".spike_rej"},   8'(spike_rej),   8'(esr));
    endtask

    // Called at a negedge: drive one sample for one cycle, expect the result
    // at the following negedge (one-cycle latency).
    task automatic send(input string tag, input logic [4:0] s, input logic [4:0] et,
                        input logic ev, input logic esr);
        exp_t e;
        e.temp  = et;
        e.valid = ev;
        e.stl   = 1'b0;
        e.spk   = esr;
        sb.push_back(e);
        sample_valid = 1'b1;
        sample       = s;
        @(negedge clk);
        sample_valid = 1'b0;
        sample       = 5'd0;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            chk_out(tag, e.temp, e.valid, e.stl, e.spk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = 5'd0;
        idle(2);
        chk_out("reset", 5'd20, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Fill: neutral until the 4th sample, then (20+22+24+26)/4 = 23.
        send("fill1", 5'd20, 5'd20, 1'b0, 1'b0);
        send("fill2", 5'd22, 5'd20, 1'b0, 1'b0);
        send("fill3", 5'd24, 5'd20, 1'b0, 1'b0);
        send("fill4", 5'd26, 5'd23, 1'b1, 1'b0);

        // Slide to an all-20 window, then 24 (|24-20| = 4, on the band edge) -> 21.
        send("slide1", 5'd20, 5'd23, 1'b1, 1'b0);
        send("slide2", 5'd20, 5'd22, 1'b1, 1'b0);
        send("slide3", 5'd20, 5'd21, 1'b1, 1'b0);
        send("slide4", 5'd20, 5'd20, 1'b1, 1'b0);
        send("slide24", 5'd24, 5'd21, 1'b1, 1'b0);

        // Back to RUN at 20 with window {20,20,20,20}.
        send("back1", 5'd20, 5'd21, 1'b1, 1'b0);
        send("back2", 5'd20, 5'd21, 1'b1, 1'b0);
        send("back3", 5'd20, 5'd21, 1'b1, 1'b0);
        send("back4", 5'd20, 5'd20, 1'b1, 1'b0);

`ifdef TEMP_FILTER_SPIKE_REJECT_EN
        send("spike1", 5'd28, 5'd20, 1'b1, 1'b1);
        send("spike2", 5'd28, 5'd20, 1'b1, 1'b1);
        send("spike3", 5'd28, 5'd22, 1'b1, 1'b0);
`else
        send("nospike", 5'd28, 5'd22, 1'b1, 1'b0);
`endif

        // Sample on the exact timeout cycle wins: window {24,28,20,20} -> 23.
        idle(8);
        chk_out("tocycle", 5'd22, 1'b1, 1'b0, 1'b0);
        send("simul", 5'd24, 5'd23, 1'b1, 1'b0);

        // Timeout: still holding after 8 idle cycles, stale on the next.
        idle(8);
        chk_out("idle8", 5'd23, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk_out("stale", 5'd20, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk_out("stale_hold", 5'd20, 1'b0, 1'b1, 1'b0);

        // Recovery: 18 becomes entry 1, so three more samples complete the fill.
        // Large steps are not rejected in FILL: (18+31+31+31)/4 = 27.
        send("recover", 5'd18, 5'd20, 1'b0, 1'b0);
        send("refill2", 5'd31, 5'd20, 1'b0, 1'b0);
        send("refill3", 5'd31, 5'd20, 1'b0, 1'b0);
        send("refill4", 5'd31, 5'd27, 1'b1, 1'b0);

        // Walk down to 25.
        send("walk1", 5'd25, 5'd29, 1'b1, 1'b0);
        send("walk2", 5'd25, 5'd28, 1'b1, 1'b0);
        send("walk3", 5'd25, 5'd26, 1'b1, 1'b0);
        send("walk4", 5'd25, 5'd25, 1'b1, 1'b0);

        // Reset mid-RUN discards history.
        rst = 1'b1;
        idle(1);
        chk_out("midrst", 5'd20, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send("post1", 5'd30, 5'd20, 1'b0, 1'b0);
        send("post2", 5'd30, 5'd20, 1'b0, 1'b0);
        send("post3", 5'd30, 5'd20, 1'b0, 1'b0);
        send("post4", 5'd30, 5'd30, 1'b1, 1'b0);

        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
